// File: rtl/btn_cond_pkg.sv
// rtl/btn_cond_pkg.sv - shared debounce state encodings and default timing constants
package btn_cond_pkg;

    // Debounce FSM state encoding; W_* are the "waiting to confirm" states
    typedef enum logic [1:0] {
        S_LO = 2'b00,
        W_HI = 2'b01,
        S_HI = 2'b11,
        W_LO = 2'b10
    } deb_state_t;

    // Default timing, also reused by the counter-stage benches
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_DEB_CYCLES    = 16;
    localparam int DEF_REPEAT_DELAY  = 64;
    localparam int DEF_REPEAT_PERIOD = 16;

endpackage

// File: rtl/btn_cond_sync_ff.sv
// rtl/btn_cond_sync_ff.sv - parameterised flop-chain synchronizer, clears to 0
module btn_cond_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous level through the chain; only the last stage is used
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_cond.sv
// rtl/btn_cond.sv - button conditioner: synchronizer, debounce FSM, rise/fall pulses (auto-repeat under BTN_COND_AUTOREPEAT_EN)
module btn_cond
    import btn_cond_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic x,
    output logic x_rise,
    output logic x_fall
);

    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    // Out-of-range configurations are rejected at elaboration
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEB_CYCLES < 2 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
        $error("btn_cond: illegal parameter value");
    end

    logic          s;
    deb_state_t    state;
    logic [CW-1:0] cnt;
    logic          repeat_pulse;
    logic          in_hold;

    btn_cond_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s)
    );

    // Debounce FSM: a new level is accepted only after DEB_CYCLES identical samples
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_LO;
            cnt    <= '0;
            x      <= 1'b0;
            x_rise <= 1'b0;
            x_fall <= 1'b0;
        end else begin
            x_rise <= 1'b0;
            x_fall <= 1'b0;
            case (state)
                S_LO: begin
                    if (s) begin
                        state <= W_HI;
                        cnt   <= CW'(1);
                    end
                end
                W_HI: begin
                    if (!s) begin
                        state <= S_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= S_HI;
                        cnt    <= '0;
                        x      <= 1'b1;
                        x_rise <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_HI: begin
                    if (!s) begin
                        state <= W_LO;
                        cnt   <= CW'(1);
                    end else begin
                        x_rise <= repeat_pulse;
                    end
                end
                W_LO: begin
                    if (s) begin
                        state <= S_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= S_LO;
                        cnt    <= '0;
                        x      <= 1'b0;
                        x_fall <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_LO;
                    cnt   <= '0;
                    x     <= 1'b0;
                end
            endcase
        end
    end

    // Staying in S_HI with s still high is the only case that can auto-repeat
    assign in_hold = (state == S_HI) && s;

`ifdef BTN_COND_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD) + 1;
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_DELAY + REPEAT_PERIOD);

    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_inc;

    assign rep_inc      = rep_cnt + RW'(1);
    assign repeat_pulse = in_hold && ((rep_inc == REP_FIRST) || (rep_inc == REP_NEXT));

    // Cycles since S_HI entry; folds back to REPEAT_DELAY so later pulses recur every REPEAT_PERIOD
    always_ff @(posedge clk) begin
        if (rst || !in_hold) begin
            rep_cnt <= '0;
        end else if (rep_inc == REP_NEXT) begin
            rep_cnt <= REP_FIRST;
        end else begin
            rep_cnt <= rep_inc;
        end
    end
`else
    assign repeat_pulse = 1'b0 & in_hold;
`endif

endmodule
